// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Holds the scan FSM state encoding, timing defaults and digit count.
// Imported by slot_timer and seg_scan_ctrl.
package seg_scan_pkg;

  localparam int NUM_DIGITS    = 8;
  localparam int CLK_DIV_DEF   = 1000;
  localparam int BLANK_CYC_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  // Extract the 8-bit segment pattern of one digit from the packed digit bus.
  function automatic logic [7:0] digit_pattern(input logic [63:0] data,
                                               input logic [2:0]  idx);
    return data[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_slot_timer.sv
// Purpose: per-slot cycle counter (0..CLK_DIV-1) flagging end of blanking and end of slot.
// Latency: flags are combinational decodes of the registered count.
// Backpressure: none; count is held at 0 whenever run_i is low.
module slot_timer
  import seg_scan_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic run_i,
  output logic blank_done_o,
  output logic slot_done_o
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign blank_done_o = (cnt_q == CW'(BLANK_CYC - 1));
  assign slot_done_o  = (cnt_q == CW'(CLK_DIV - 1));

  // Next count: advance while scanning, wrap at slot end, park at 0 when stopped
  always_comb begin
    cnt_d = '0;
    if (run_i && !slot_done_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Slot count register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Purpose: time-multiplexed 8-digit segment scanner with per-slot blanking and digit masking.
// Latency: EN sampled at edge t -> blanking from t, first pattern at t+BLANK_CYC; all outputs registered.
// Backpressure: none; EN low abandons the slot and returns to IDLE on the next edge.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        EN,
  input  logic [63:0] DigitData,
  input  logic [7:0]  DigitEnMask,
  output logic [2:0]  OutCNT8,
  output logic [7:0]  SegOut,
  output logic        Blank,
  output logic        FrameTick
);

  state_t     state_q;
  logic [2:0] idx_q;
  logic [7:0] seg_q;
  logic       blank_q;
  logic       tick_q;

  logic       blank_done;
  logic       slot_done;
  logic       timer_run;

  // The slot timer only counts once a scan is under way; leaving IDLE starts it at 0.
  assign timer_run = EN && (state_q != ST_IDLE);

  slot_timer #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_slot_timer (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .run_i        (timer_run),
    .blank_done_o (blank_done),
    .slot_done_o  (slot_done)
  );

  // Scan FSM with digit index, latched segment pattern and frame pulse, all registered
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      seg_q   <= 8'h00;
      blank_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (!EN) begin
        state_q <= ST_IDLE;
        idx_q   <= 3'd0;
        seg_q   <= 8'h00;
        blank_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_BLANK;
            idx_q   <= 3'd0;
            seg_q   <= 8'h00;
            blank_q <= 1'b1;
          end
          ST_BLANK: begin
            if (blank_done) begin
              // Pattern is captured once per slot so mid-slot data changes cannot tear.
              state_q <= ST_DRIVE;
              seg_q   <= DigitEnMask[idx_q] ? digit_pattern(DigitData, idx_q) : 8'h00;
              blank_q <= 1'b0;
            end
          end
          ST_DRIVE: begin
            if (slot_done) begin
              // Index moves only together with segments going dark.
              state_q <= ST_BLANK;
              idx_q   <= idx_q + 3'd1;
              seg_q   <= 8'h00;
              blank_q <= 1'b1;
              tick_q  <= (idx_q == 3'(NUM_DIGITS - 1));
            end
          end
          default: begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            seg_q   <= 8'h00;
            blank_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign OutCNT8   = idx_q;
  assign SegOut    = seg_q;
  assign Blank     = blank_q;
  assign FrameTick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with CLK_DIV=8, BLANK_CYC=2.
// Directed table, hand sequences for multi-cycle corners, randomized run against a time-based model.
module tb_seg_scan_ctrl;
  localparam int CD = 8;
  localparam int BC = 2;

  logic        clk  = 1'b0;
  logic        rstn = 1'b1;
  logic        en   = 1'b0;
  logic [63:0] data = '0;
  logic [7:0]  mask = 8'hFF;
  logic [2:0]  cnt;
  logic [7:0]  seg;
  logic        blank;
  logic        ftick;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYC(BC)) dut (
    .CLK(clk), .RSTn(rstn), .EN(en), .DigitData(data), .DigitEnMask(mask),
    .OutCNT8(cnt), .SegOut(seg), .Blank(blank), .FrameTick(ftick)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at time %0t", nm, act, exp, $time);
  endtask

  // Reference model: time since scan start determines digit and position in slot.
  bit         m_run   = 1'b0;
  int         m_t     = 0;
  int         m_d;
  logic [7:0] m_lat   = 8'h00;
  logic [7:0] e_seg   = 8'h00;
  logic [2:0] e_cnt   = 3'd0;
  logic       e_blank = 1'b1;
  logic       e_tick  = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_run = 1'b0; m_t = 0;
    end else if (!en) begin
      m_run = 1'b0; m_t = 0;
    end else if (!m_run) begin
      m_run = 1'b1; m_t = 0;
    end else begin
      m_t++;
    end
    m_d = (m_t / CD) % 8;
    if (m_run && (m_t % CD) == BC) m_lat = mask[m_d] ? data[8*m_d +: 8] : 8'h00;
    e_seg   = (m_run && (m_t % CD) >= BC) ? m_lat : 8'h00;
    e_cnt   = m_run ? 3'(m_d) : 3'd0;
    e_blank = !m_run || ((m_t % CD) < BC);
    e_tick  = m_run && (m_t > 0) && ((m_t % (CD * 8)) == 0);
  end

  always @(negedge clk) begin
    chk("mdl_seg", seg, e_seg);
    chk("mdl_cnt", 8'(cnt), 8'(e_cnt));
    chk("mdl_blank", 8'(blank), 8'(e_blank));
    chk("mdl_tick", 8'(ftick), 8'(e_tick));
  end

  typedef struct {
    logic       en;
    logic [7:0] seg;
    logic [2:0] cnt;
    logic       blank;
    logic       tick;
  } vec_t;
  vec_t tbl[16];

  int ticks;
  int tick_at;

  task automatic restart();
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'h00, 3'd0, 1'b1, 1'b0}; tbl[1]  = '{1'b1, 8'h00, 3'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 8'h10, 3'd0, 1'b0, 1'b0}; tbl[3]  = '{1'b1, 8'h10, 3'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'h10, 3'd0, 1'b0, 1'b0}; tbl[5]  = '{1'b1, 8'h10, 3'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'h10, 3'd0, 1'b0, 1'b0}; tbl[7]  = '{1'b1, 8'h10, 3'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'h00, 3'd1, 1'b1, 1'b0}; tbl[9]  = '{1'b1, 8'h00, 3'd1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 8'h11, 3'd1, 1'b0, 1'b0}; tbl[11] = '{1'b1, 8'h11, 3'd1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 8'h11, 3'd1, 1'b0, 1'b0}; tbl[13] = '{1'b1, 8'h11, 3'd1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 8'h11, 3'd1, 1'b0, 1'b0}; tbl[15] = '{1'b1, 8'h11, 3'd1, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) data[8*k +: 8] = 8'h10 + 8'(k);

    // Asynchronous reset values
    #1 rstn = 1'b0;
    #1;
    chk("rst_seg", seg, 8'h00);
    chk("rst_cnt", 8'(cnt), 8'd0);
    chk("rst_blank", 8'(blank), 8'd1);
    chk("rst_tick", 8'(ftick), 8'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_blank", 8'(blank), 8'd1);

    // Directed start-up sequence
    for (int i = 0; i < 16; i++) begin
      en = tbl[i].en;
      @(negedge clk);
      chk($sformatf("tbl%0d_seg", i), seg, tbl[i].seg);
      chk($sformatf("tbl%0d_cnt", i), 8'(cnt), 8'(tbl[i].cnt));
      chk($sformatf("tbl%0d_blank", i), 8'(blank), 8'(tbl[i].blank));
      chk($sformatf("tbl%0d_tick", i), 8'(ftick), 8'(tbl[i].tick));
    end

    // One FrameTick per frame, at the 7->0 wrap only
    ticks = 0; tick_at = -1;
    for (int t = 16; t <= 70; t++) begin
      @(negedge clk);
      if (ftick) begin ticks++; tick_at = t; end
    end
    chk("ftick_count", 8'(ticks), 8'd1);
    chk("ftick_cycle", 8'(tick_at), 8'd64);

    // Masked digit 2 stays dark for its full slot
    mask = 8'hFB;
    restart();
    for (int t = 1; t <= 26; t++) begin
      @(negedge clk);
      if (t == 10) chk("mask_prev", seg, 8'h11);
      if (t >= 16 && t <= 23) begin
        chk("mask_seg", seg, 8'h00);
        chk("mask_cnt", 8'(cnt), 8'd2);
      end
      if (t == 26) chk("mask_next", seg, 8'h13);
    end

    // Mid-slot data change affects only the next visit
    mask = 8'hFF;
    data[7:0] = 8'h3F;
    restart();
    repeat (4) @(negedge clk);
    data[7:0] = 8'h06;
    repeat (3) @(negedge clk);
    chk("tear_hold", seg, 8'h3F);
    repeat (59) @(negedge clk);
    chk("tear_next", seg, 8'h06);

    // EN drop in digit 5 drive, then restart
    restart();
    repeat (43) @(negedge clk);
    chk("en_pre_seg", seg, 8'h15);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_seg", seg, 8'h00);
    chk("en_off_blank", 8'(blank), 8'd1);
    chk("en_off_cnt", 8'(cnt), 8'd0);
    en = 1'b1;
    @(negedge clk);
    chk("en_on_b0", 8'(blank), 8'd1);
    @(negedge clk);
    chk("en_on_b1", 8'(blank), 8'd1);
    @(negedge clk);
    chk("en_on_seg", seg, 8'h06);
    chk("en_on_cnt", 8'(cnt), 8'd0);

    // Reset asserted between edges during drive acts immediately
    restart();
    repeat (12) @(negedge clk);
    chk("pre_rst_cnt", 8'(cnt), 8'd1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_seg", seg, 8'h00);
    chk("mid_rst_cnt", 8'(cnt), 8'd0);
    chk("mid_rst_blank", 8'(blank), 8'd1);
    @(negedge clk);
    rstn = 1'b1;

    // Randomized run against the model
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      en = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 15) == 0) data = {$urandom, $urandom};
      if ($urandom_range(0, 31) == 0) mask = 8'($urandom);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 1000: clock cycles per digit slot; legal range CLK_DIV >= BLANK_CYC+2.
REQ-002 Parameter BLANK_CYC, default 16: blanking cycles at the start of each slot; legal minimum 1.
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 RSTn  in  1  reset; asynchronous, active-low.
REQ-005 EN  in  1  scan enable; 0 stops the scan and blanks the display.
REQ-006 DigitData  in  64  segment patterns, 8 bits per digit, active-high; digit k at bits [8k+7:8k].
REQ-007 DigitEnMask  in  8  per-digit enable; bit k=0 keeps digit k dark.
REQ-008 OutCNT8  out  3  current digit index; drives the downstream common selector's 3-bit count input.
REQ-009 SegOut  out  8  registered segment drive, active-high; 8'h00 = all segments off.
REQ-010 Blank  out  1  1 whenever SegOut is forced off (IDLE or BLANK state).
REQ-011 FrameTick  out  1  one-cycle pulse when OutCNT8 wraps from 7 to 0.

Function
REQ-012 FSM states: IDLE, BLANK, DRIVE; all outputs registered.
REQ-013 IDLE: OutCNT8=0, SegOut=8'h00, Blank=1, FrameTick=0, slot counter=0.
REQ-014 IDLE->BLANK on the first edge with EN=1; slot counter starts at 0.
REQ-015 BLANK lasts exactly BLANK_CYC cycles: SegOut=8'h00, Blank=1, OutCNT8 holds.
REQ-016 BLANK->DRIVE after BLANK_CYC cycles; on entry, SegOut latches DigitData[8*OutCNT8+:8] if DigitEnMask[OutCNT8]=1, otherwise 8'h00.
REQ-017 SegOut holds the latched pattern for the whole DRIVE phase; DigitData changes mid-slot take effect in the next slot (no tearing).
REQ-018 DRIVE lasts CLK_DIV-BLANK_CYC cycles, so every slot is exactly CLK_DIV cycles.
REQ-019 At the end of DRIVE: OutCNT8 increments modulo 8, SegOut returns to 8'h00, and the state returns to BLANK.
REQ-020 The index change coincides with the start of BLANK; OutCNT8 never changes while SegOut is non-zero.
REQ-021 FrameTick=1 for exactly the one cycle in which OutCNT8 first shows 0 after 7; it does not pulse on the IDLE->BLANK start.
REQ-022 Masked digits keep their full slot time, so scan period and brightness stay uniform.
REQ-023 EN=0 in any state: next edge enters IDLE with the REQ-013 values; a partial slot is abandoned.
REQ-024 EN toggled 0->1: scan restarts at digit 0 with a full BLANK phase.
REQ-025 Frame period = 8*CLK_DIV cycles while EN=1.
REQ-026 Latency: EN rises and is sampled at edge t -> Blank=1 from t; first SegOut pattern at edge t+BLANK_CYC.

Reset
REQ-027 RSTn=0 asynchronously forces IDLE, OutCNT8=0, SegOut=8'h00, Blank=1, FrameTick=0, and clears all counters.
REQ-028 Release is sampled synchronously; the first transition out of IDLE occurs no earlier than the first edge after release.
REQ-029 Reset asserted mid-DRIVE clears SegOut in the same cycle, without waiting for a clock edge.

Structure
REQ-030 Shared package seg_scan_pkg holds the state enum (IDLE/BLANK/DRIVE), CLK_DIV and BLANK_CYC defaults, and the digit-count constant 8.
REQ-031 One sub-module, slot_timer: counts 0..CLK_DIV-1 and flags blank_done and slot_done; seg_scan_ctrl contains the FSM, index counter and data mux.
REQ-032 OutCNT8 connects directly to the common selector; seg_scan_ctrl contains no common-line decoding.

Verification (CLK_DIV=8, BLANK_CYC=2)
REQ-033 Reset release, EN=1, DigitData digit k = 8'h10+k, mask 8'hFF -> SegOut sequence: 00,00,10 x6, 00,00,11 x6 ...; OutCNT8 steps every 8 cycles.
REQ-034 Run 64 cycles from start -> FrameTick pulses once, at cycle 64 when OutCNT8 goes 7->0; it does not pulse at start.
REQ-035 DigitEnMask=8'hFB -> digit 2 slot shows SegOut=00 for all 8 cycles with OutCNT8=2; the neighbouring slots are unaffected.
REQ-036 Change digit 0 data from 8'h3F to 8'h06 mid-DRIVE -> current slot keeps 3F; next visit to digit 0 shows 06.
REQ-037 EN=0 mid-DRIVE of digit 5 -> next cycle SegOut=00, Blank=1, OutCNT8=0; EN=1 -> restart at digit 0 after 2 blank cycles.
REQ-038 RSTn pulsed low between edges during DRIVE -> SegOut=00, OutCNT8=0 immediately, without waiting for a clock edge.
